// File: rtl/reg_4_arbiter.sv
// reg_4_arbiter: four requesters arbitrate round-robin for one shared 4-bit
// register; each granted requester writes its d_bus nibble.
//
// Ports:
//   clk     - sole clock, all state updates on the rising edge
//   reset   - synchronous, active-low reset
//   req     - level request per requester, held until its ack
//   d_bus   - write data, requester i drives d_bus[4i+3:4i]
//   gnt     - registered one-hot grant, zero when nobody owns the bus
//   ack     - registered one-cycle pulse marking requester i's write
//   q       - shared register contents
//   q0      - registered complement of q
//   owner   - index of the last requester that completed a write
//   busy    - high whenever the FSM is not idle
//   wr_cnt  - completed write count, wraps 255 -> 0

module reg_4_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] d_bus,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [3:0]  q,
    output logic [3:0]  q0,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [7:0]  wr_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel;

    // Round-robin pick: scan from ptr upward (mod 4). The loop runs from
    // the farthest offset down so the nearest requester overwrites last
    // and therefore wins.
    logic [1:0] win;
    logic       win_valid;
    logic [1:0] idx;

    always_comb begin
        win       = 2'b00;
        win_valid = 1'b0;
        idx       = 2'b00;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win       = idx;
                win_valid = 1'b1;
            end
        end
    end

    // Data nibble of the currently selected requester.
    logic [3:0] sel_data;

    always_comb begin
        sel_data = 4'b0000;
        case (sel)
            2'd0:    sel_data = d_bus[3:0];
            2'd1:    sel_data = d_bus[7:4];
            2'd2:    sel_data = d_bus[11:8];
            default: sel_data = d_bus[15:12];
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= 4'b0000;
            ack    <= 4'b0000;
            q      <= 4'b0000;
            q0     <= 4'b1111;
            owner  <= 2'b00;
            ptr    <= 2'b00;
            sel    <= 2'b00;
            wr_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 4'b0000;
                    if (win_valid) begin
                        gnt   <= 4'b0001 << win;
                        sel   <= win;
                        state <= GRANT;
                    end else begin
                        gnt   <= 4'b0000;
                        state <= IDLE;
                    end
                end

                GRANT: begin
                    if (req[sel]) begin
                        q      <= sel_data;
                        q0     <= ~sel_data;
                        ack    <= 4'b0001 << sel;
                        owner  <= sel;
                        wr_cnt <= wr_cnt + 8'd1;
                        state  <= WRITE;
                    end else begin
                        // Requester gave up before its write: release the
                        // bus without touching data, count or pointer.
                        gnt   <= 4'b0000;
                        ack   <= 4'b0000;
                        state <= IDLE;
                    end
                end

                WRITE: begin
                    gnt   <= 4'b0000;
                    ack   <= 4'b0000;
                    ptr   <= sel + 2'd1;
                    state <= IDLE;
                end

                default: begin
                    gnt   <= 4'b0000;
                    ack   <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_4_arbiter.sv
// Self-checking bench for reg_4_arbiter: a directed vector table plus
// hand-written round-robin and counter-wrap sequences.

module tb_reg_4_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] d_bus;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  q;
    logic [3:0]  q0;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  wr_cnt;

    always #5 clk = ~clk;

    reg_4_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .d_bus  (d_bus),
        .gnt    (gnt),
        .ack    (ack),
        .q      (q),
        .q0     (q0),
        .owner  (owner),
        .busy   (busy),
        .wr_cnt (wr_cnt)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] d;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [3:0]  q;
        logic [3:0]  qb;
        logic [1:0]  own;
        logic        bsy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tv[$];

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later and check the invariants.
    task automatic step();
        @(posedge clk);
        #1;
        chk("q0_is_not_q", 32'(q0 ^ q), 32'hF);
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        chk("ack_implies_gnt", 32'((ack & ~gnt) == 4'b0000), 32'd1);
    endtask

    task automatic add(input logic rst, input logic [3:0] rq,
                       input logic [15:0] d, input logic [3:0] g,
                       input logic [3:0] a, input logic [3:0] qq,
                       input logic [3:0] qb, input logic [1:0] ow,
                       input logic bs, input logic [7:0] c);
        vec_t v;
        v = '{rst, rq, d, g, a, qq, qb, ow, bs, c};
        tv.push_back(v);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b0;
        req   = 4'b0000;
        d_bus = 16'h0000;
        #1;

        //   rst req      d_bus     gnt      ack      q     q0    own bsy cnt
        // Reset state
        add(0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h0, 4'hF, 0, 0, 0);
        // Single write by requester 0, data 1010
        add(1, 4'b0001, 16'h000A, 4'b0001, 4'b0000, 4'h0, 4'hF, 0, 1, 0);
        add(1, 4'b0001, 16'h000A, 4'b0001, 4'b0001, 4'hA, 4'h5, 0, 1, 1);
        add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'hA, 4'h5, 0, 0, 1);
        // d_bus changes outside the GRANT->WRITE edge are ignored
        add(1, 4'b0010, 16'h0030, 4'b0010, 4'b0000, 4'hA, 4'h5, 0, 1, 1);
        add(1, 4'b0010, 16'h0060, 4'b0010, 4'b0010, 4'h6, 4'h9, 1, 1, 2);
        add(1, 4'b0000, 16'h00F0, 4'b0000, 4'b0000, 4'h6, 4'h9, 1, 0, 2);
        add(1, 4'b0000, 16'hFFFF, 4'b0000, 4'b0000, 4'h6, 4'h9, 1, 0, 2);
        // Requester 2 abandons in GRANT, then retries
        add(1, 4'b0100, 16'h0000, 4'b0100, 4'b0000, 4'h6, 4'h9, 1, 1, 2);
        add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h6, 4'h9, 1, 0, 2);
        add(1, 4'b0100, 16'h0000, 4'b0100, 4'b0000, 4'h6, 4'h9, 1, 1, 2);
        add(1, 4'b0100, 16'h0700, 4'b0100, 4'b0100, 4'h7, 4'h8, 2, 1, 3);
        add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h7, 4'h8, 2, 0, 3);
        // ptr=3: abandon must not advance ptr, so 3 beats 0 again
        add(1, 4'b1001, 16'h0000, 4'b1000, 4'b0000, 4'h7, 4'h8, 2, 1, 3);
        add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h7, 4'h8, 2, 0, 3);
        add(1, 4'b1001, 16'h0000, 4'b1000, 4'b0000, 4'h7, 4'h8, 2, 1, 3);
        add(1, 4'b1001, 16'h5000, 4'b1000, 4'b1000, 4'h5, 4'hA, 3, 1, 4);
        // Requests during WRITE are ignored
        add(1, 4'b0001, 16'h0000, 4'b0000, 4'b0000, 4'h5, 4'hA, 3, 0, 4);
        add(1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 4'h5, 4'hA, 3, 1, 4);
        add(1, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 4'h3, 4'hC, 0, 1, 5);
        // Reset while in WRITE discards everything
        add(0, 4'b0001, 16'h0003, 4'b0000, 4'b0000, 4'h0, 4'hF, 0, 0, 0);
        add(1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'h0, 4'hF, 0, 0, 0);

        foreach (tv[i]) begin
            reset = tv[i].rst;
            req   = tv[i].req;
            d_bus = tv[i].d;
            step();
            chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
            chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("v%0d_q", i), 32'(q), 32'(tv[i].q));
            chk($sformatf("v%0d_q0", i), 32'(q0), 32'(tv[i].qb));
            chk($sformatf("v%0d_owner", i), 32'(owner), 32'(tv[i].own));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("v%0d_cnt", i), 32'(wr_cnt), 32'(tv[i].cnt));
        end

        // Round-robin: all four requesting continuously from reset
        reset = 1'b0;
        req   = 4'b0000;
        step();
        reset = 1'b1;
        req   = 4'b1111;
        d_bus = 16'h4321;
        for (int r = 0; r < 5; r++) begin
            step();
            chk($sformatf("rr%0d_gnt", r), 32'(gnt), 32'(4'b0001 << order[r]));
            chk($sformatf("rr%0d_busy", r), 32'(busy), 32'd1);
            step();
            chk($sformatf("rr%0d_ack", r), 32'(ack), 32'(4'b0001 << order[r]));
            chk($sformatf("rr%0d_owner", r), 32'(owner), 32'(order[r]));
            chk($sformatf("rr%0d_q", r), 32'(q), 32'(order[r] + 1));
            chk($sformatf("rr%0d_cnt", r), 32'(wr_cnt), 32'(r + 1));
            step();
            chk($sformatf("rr%0d_gnt_off", r), 32'(gnt), 32'd0);
            chk($sformatf("rr%0d_ack_off", r), 32'(ack), 32'd0);
        end

        // 256 back-to-back writes by requester 0, counter must wrap
        reset = 1'b0;
        req   = 4'b0000;
        step();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] nib;
            nib   = 4'(i);
            d_bus = {4{nib}};
            req   = 4'b0001;
            step();
            chk("wrap_gnt", 32'(gnt), 32'h1);
            step();
            chk("wrap_q", 32'(q), 32'(nib));
            chk("wrap_cnt", 32'(wr_cnt), 32'((i + 1) % 256));
            step();
        end
        chk("wrap_final_cnt", 32'(wr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
